// File: rtl/prio_enc_pkg.sv
// Shared types, widths and the highest-set-bit helper for the 8-to-3 priority encoder.
package prio_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RELEASE
    } state_t;

    // Index of the highest set bit; an all-zero vector maps to 0.
    function automatic logic [CODE_W-1:0] hi_idx(input logic [N_REQ-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) r = CODE_W'(i);
        end
        return r;
    endfunction

    // Bits strictly above position c.
    function automatic logic [N_REQ-1:0] above_mask(input logic [CODE_W-1:0] c);
        logic [N_REQ:0] t;
        t = ((N_REQ+1)'(2) << c) - (N_REQ+1)'(1);
        return ~t[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/prio_enc_8to3_sync_2ff.sv
// Single-bit two-flop synchronizer; resets to 1 so an active-low request line reads idle.
module prio_enc_8to3_sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            q_o    <= 1'b1;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/prio_enc_8to3.sv
// Registered 8-to-3 priority encoder with 74148-style cascade pins and valid/ready output.
// Define PRIO_ENC_SYNC_EN to pass in_n_i through a two-flop synchronizer (+2 cycles latency).
module prio_enc_8to3
    import prio_enc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N_REQ-1:0]  in_n_i,
    input  logic              ei_n_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              gs_n_o,
    output logic              eo_n_o,
    output logic [CNT_W-1:0]  evt_cnt_o
);

    logic [N_REQ-1:0]  in_n_s;
    logic [N_REQ-1:0]  req;
    logic [CODE_W-1:0] hi;
    logic              hi_above;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_inc;
    logic              gs_n_q, eo_n_q;

`ifdef PRIO_ENC_SYNC_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_sync
        prio_enc_8to3_sync_2ff u_sync (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .d_i     (in_n_i[g]),
            .q_o     (in_n_s[g])
        );
    end
`else
    assign in_n_s = in_n_i;
`endif

    // Enable gates the sampled vector; it is deliberately not synchronized.
    assign req      = ei_n_i ? '0 : ~in_n_s;
    assign hi       = hi_idx(req);
    assign hi_above = |(req & above_mask(code_q));

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    code_d  = hi;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    cnt_inc = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // A still-held reported line is not re-reported; only a higher one preempts.
                if (hi_above) begin
                    code_d  = hi;
                    state_d = HOLD;
                end else if (!req[code_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            gs_n_q  <= 1'b1;
            eo_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
            gs_n_q  <= ~(|req);
            eo_n_q  <= ei_n_i | (|req);
        end
    end

    assign valid_o   = (state_q == HOLD);
    assign code_o    = code_q;
    assign evt_cnt_o = cnt_q;
    assign gs_n_o    = gs_n_q;
    assign eo_n_o    = eo_n_q;

endmodule

// File: tb/tb_prio_enc_8to3.sv
// Randomized + directed bench for prio_enc_8to3 against an episode-level reference model.
module tb_prio_enc_8to3;

`ifdef PRIO_ENC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_n;
    logic       ei_n;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] evt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    prio_enc_8to3 dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .in_n_i    (in_n),
        .ei_n_i    (ei_n),
        .code_o    (code),
        .valid_o   (valid),
        .ready_i   (ready),
        .gs_n_o    (gs_n),
        .eo_n_o    (eo_n),
        .evt_cnt_o (evt_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an outstanding report, or the index last accepted that is still held.
    logic            m_valid;
    int              m_code;
    int              m_ack;     // -1: nothing accepted is pending release
    int              m_cnt;
    logic            m_gs_n, m_eo_n;
    logic [1:0][7:0] hist;

    function automatic int top_bit(input logic [7:0] v);
        int t;
        t = -1;
        for (int i = 0; i < 8; i++) if (v[i]) t = i;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] s;
        logic [7:0] rq;
        int         t;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_code  <= 0;
            m_ack   <= -1;
            m_cnt   <= 0;
            m_gs_n  <= 1'b1;
            m_eo_n  <= 1'b1;
            hist    <= {8'hFF, 8'hFF};
        end else begin
            s    = (LAT == 2) ? hist[1] : in_n;
            hist <= {hist[0], in_n};
            rq   = ei_n ? 8'h00 : ~s;
            t    = top_bit(rq);
            m_gs_n <= (t < 0);
            m_eo_n <= ei_n || (t >= 0);
            if (m_valid) begin
                if (ready) begin
                    m_valid <= 1'b0;
                    m_cnt   <= (m_cnt + 1) % 256;
                    m_ack   <= m_code;
                end
            end else if (m_ack < 0) begin
                if (t >= 0) begin
                    m_valid <= 1'b1;
                    m_code  <= t;
                end
            end else if (t > m_ack) begin
                m_valid <= 1'b1;
                m_code  <= t;
                m_ack   <= -1;
            end else if (!rq[m_ack]) begin
                m_ack <= -1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model.valid", int'(valid), int'(m_valid));
        if (m_valid) chk("model.code", int'(code), m_code);
        chk("model.gs_n", int'(gs_n), int'(m_gs_n));
        chk("model.eo_n", int'(eo_n), int'(m_eo_n));
        chk("model.cnt", int'(evt_cnt), m_cnt);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_n = 8'hFF; ei_n = 1'b0; ready = 1'b0;
        step(2);
        chk("rst.valid", int'(valid), 0);
        chk("rst.code", int'(code), 0);
        chk("rst.gs_n", int'(gs_n), 1);
        chk("rst.eo_n", int'(eo_n), 1);
        chk("rst.cnt", int'(evt_cnt), 0);
        rst_n = 1'b1;
        step(1 + LAT);
        chk("idle.valid", int'(valid), 0);
        chk("idle.gs_n", int'(gs_n), 1);
        chk("idle.eo_n", int'(eo_n), 0);
        chk("idle.cnt", int'(evt_cnt), 0);

        // Priority: bits 6 and 4 active
        ready = 1'b1; in_n = 8'b1010_1111;
        step(1 + LAT);
        chk("prio.valid6", int'(valid), 1);
        chk("prio.code6", int'(code), 6);
        chk("prio.gs_n", int'(gs_n), 0);
        step(1);
        chk("prio.onecycle", int'(valid), 0);
        step(3);
        chk("prio.norereport", int'(valid), 0);
        in_n = 8'b1110_1111;
        step(1 + LAT);
        chk("prio.idlegap", int'(valid), 0);
        step(1);
        chk("prio.valid4", int'(valid), 1);
        chk("prio.code4", int'(code), 4);
        in_n = 8'hFF;
        step(2 + LAT);
        chk("prio.cnt", int'(evt_cnt), 2);

        // Freeze and preempt
        ready = 1'b0; in_n = 8'b1111_1011;
        step(1 + LAT);
        chk("frz.code2", int'(code), 2);
        in_n = 8'b1101_1011;
        step(1 + LAT);
        chk("frz.valid", int'(valid), 1);
        chk("frz.frozen", int'(code), 2);
        ready = 1'b1;
        step(1);
        chk("frz.release", int'(valid), 0);
        step(1);
        chk("frz.valid5", int'(valid), 1);
        chk("frz.code5", int'(code), 5);
        in_n = 8'hFF;
        step(2 + LAT);
        chk("frz.cnt", int'(evt_cnt), 4);

        // Enable gating
        ready = 1'b0; ei_n = 1'b1; in_n = 8'h00;
        step(1);
        chk("en.gs_n", int'(gs_n), 1);
        chk("en.eo_n", int'(eo_n), 1);
        step(3);
        chk("en.novalid", int'(valid), 0);
        ei_n = 1'b0;
        step(1);
        chk("en.code7", int'(code), 7);
        ei_n = 1'b1;
        step(2);
        chk("en.held", int'(valid), 1);
        ready = 1'b1;
        step(1);
        chk("en.done", int'(evt_cnt), 5);
        ready = 1'b0; in_n = 8'hFF;
        step(1 + LAT);
        ei_n = 1'b0;
        step(2);

        // Counter wrap
        ready = 1'b1;
        for (int i = 0; i < 251; i++) begin
            in_n = 8'hFE;
            step(2 + LAT);
            in_n = 8'hFF;
            step(2 + LAT);
            if (i == 249) chk("wrap.255", int'(evt_cnt), 255);
        end
        chk("wrap.0", int'(evt_cnt), 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_n  = 8'($urandom) | 8'($urandom) | 8'($urandom);
            ei_n  = ($urandom_range(0, 9) == 0);
            ready = ($urandom_range(0, 2) != 0);
            step($urandom_range(1, 3));
        end

        // Async reset mid-HOLD
        ready = 1'b0; ei_n = 1'b0; in_n = 8'hFF;
        step(3 + LAT);
        in_n = 8'hF7;
        step(1 + LAT);
        chk("ares.hold", int'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ares.valid", int'(valid), 0);
        chk("ares.code", int'(code), 0);
        chk("ares.cnt", int'(evt_cnt), 0);
        chk("ares.gs_n", int'(gs_n), 1);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_enc_8to3.md
# prio_enc_8to3

Registered 8-to-3 priority encoder with 74148-style cascade pins and a valid/ready output handshake. It is the encoding counterpart of the team's 3-to-8 decoder. It watches eight active-low request lines and reports the index of the highest-priority active line exactly once per request episode. Each code is held stable until the consumer accepts it. It sits between request/interrupt-style lines and a bus-side consumer.

## Interface
Parameters:
- none; widths are fixed at 8 inputs and 3 code bits, taken from the package.

Ports (name, direction, width, meaning):
- clk_i, input, 1, sole clock, rising edge.
- rst_n_i, input, 1, asynchronous, active-low reset.
- in_n_i, input, 8, request lines, active-low; bit 7 has highest priority.
- ei_n_i, input, 1, enable input, active-low.
- code_o, output, 3, binary index of the reported request, true polarity.
- valid_o, output, 1, code_o is valid.
- ready_i, input, 1, consumer accepts code_o when valid_o && ready_i.
- gs_n_o, output, 1, group select, active-low, registered: low when enabled and any request is active.
- eo_n_o, output, 1, enable output, active-low, registered: low when enabled and no request is active.
- evt_cnt_o, output, 8, count of accepted handshakes.

## Operation
- Sampled vector: req = ~in_n (post-synchronizer when enabled), ANDed with ~ei_n_i. ei_n_i is never synchronized.
- hi = index of the highest set bit of req.
- FSM state_t has three states: IDLE, HOLD and RELEASE.
- IDLE: valid_o=0.
  - If req != 0: code_q <= hi, go to HOLD.
- HOLD: valid_o=1 and code_o=code_q, frozen.
  - Higher-priority arrivals do not alter code_o.
  - ei_n_i deassertion does not abort the handshake.
  - On ready_i: go to RELEASE and increment evt_cnt_o.
- RELEASE: valid_o=0. Evaluate in this priority order:
  1. If any req bit above code_q is set: code_q <= hi, go to HOLD.
  2. Else if req[code_q]==0: go to IDLE.
  3. Else stay in RELEASE.
- Each request episode is therefore reported once.
- Lower-priority lines still active when the FSM returns to IDLE are reported starting from IDLE. This costs one extra cycle.
- evt_cnt_o is 8 bits and wraps from 255 to 0. It is not saturating.
- gs_n_o and eo_n_o are registered from the same sampled vector every cycle, independent of FSM state.
  - When ei_n_i=1: gs_n_o=1 and eo_n_o=1.
  - gs_n_o and eo_n_o are never both low.

## Timing
- Reset values: state IDLE, code_o=0, valid_o=0, gs_n_o=1, eo_n_o=1, evt_cnt_o=0, synchronizer flops all 1 (inactive).
- Without the synchronizer:
  - A request present at rising edge N produces valid_o=1 and the correct code_o after edge N.
  - gs_n_o and eo_n_o update after edge N.
- With the synchronizer: add 2 cycles to both of the paths above.
- The accepting edge (valid_o && ready_i high) moves the FSM HOLD to RELEASE. valid_o is 0 the cycle after the accepting edge.
- Back-to-back reporting:
  - The earliest next valid_o is two edges after the accepting edge, going through RELEASE and back to HOLD.
  - Back-to-back valid_o is never asserted.
- ready_i may be held high permanently. Each HOLD then lasts exactly one cycle.
- Reset asserted mid-HOLD:
  - All outputs return to reset values immediately, asynchronously.
  - The pending code is lost and evt_cnt_o is not incremented.

## Configuration
- Macro: PRIO_ENC_SYNC_EN.
- Defined: each bit of in_n_i passes through a two-flop synchronizer before sampling. The synchronizer resets to 1. Latency is +2 cycles.
- Undefined: in_n_i is sampled directly, and the caller guarantees it is synchronous to clk_i.
- No other behaviour differs.

## Structure
- Package prio_enc_pkg holds:
  - state_t enum {IDLE, HOLD, RELEASE};
  - localparams N_REQ=8, CODE_W=3, CNT_W=8;
  - a function returning hi for an 8-bit vector, which returns 0 for an all-zero vector.
- Sub-module sync_2ff: per-bit two-flop synchronizer with asynchronous active-low reset, reset value 1. It is instantiated only under PRIO_ENC_SYNC_EN.

## Test plan
- Reset and idle:
  - Stimulus: in_n_i=8'hFF, ei_n_i=0.
  - Response: valid_o=0, gs_n_o=1, eo_n_o=0, evt_cnt_o=0.
- Priority:
  - Stimulus: in_n_i=8'b1010_1111 (bits 6 and 4 active), ready_i=1.
  - Response: code_o=6 and valid_o for one cycle; then no re-report while bit 6 is held.
  - Stimulus: release bit 6.
  - Response: code_o=4 reported from IDLE.
- Freeze and preempt:
  - Stimulus: bit 2 active, ready_i=0; then bit 5 asserts during HOLD.
  - Response: code_o stays 2.
  - Stimulus: raise ready_i.
  - Response: RELEASE, then code_o=5 valid two edges after acceptance.
- Enable gating:
  - Stimulus: ei_n_i=1 with any in_n_i.
  - Response: no valid_o, gs_n_o=1, eo_n_o=1.
  - Stimulus: ei_n_i rises during HOLD.
  - Response: the handshake still completes.
- Counter wrap: 256 accepted handshakes → evt_cnt_o returns to 0.
- Async reset mid-HOLD:
  - Stimulus: assert rst_n_i=0 between clock edges while in HOLD.
  - Response: valid_o drops immediately, code_o=0, evt_cnt_o is unchanged from its reset value.
  - Also: with PRIO_ENC_SYNC_EN defined, the request-to-valid latency is 2 cycles longer.
